mem_access_stage: RTL

//  MEM-stage engine; consumes the EX/MEM pipeline register outputs during phase 3 (phasecounter[3]).

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mem_access_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, phase bit indices, LED select bits and
// the MEM-stage FSM state encoding.
package cpu_pkg;

  localparam int MEM_DATA_W      = 16;
  localparam int MEM_DES_W       = 3;
  localparam int MEM_TIMEOUT_CYC = 15;

  localparam int PH_MEM = 3;

  localparam int LED0_BIT = 0;
  localparam int LED1_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage.sv
// MEM-stage engine: runs one data-memory access per phase-3 slot, drives the
// LED registers and the registered MEM/WB result, and stalls the phase counter.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DES_W       = MEM_DES_W,
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        phasecounter,
  input  logic              in_MemtoReg,
  input  logic              in_RegWrite,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic [1:0]        in_ledout,
  input  logic              in_switchin,
  input  logic [DATA_W-1:0] in_address,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DES_W-1:0]  in_des,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] switch_data,
  output logic              stall,
  output logic [DATA_W-1:0] led0,
  output logic [DATA_W-1:0] led1,
  output logic              wb_RegWrite,
  output logic [DES_W-1:0]  wb_des,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_error,
  output logic [1:0]        dbg_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  mem_state_e        state_q;
  logic [TO_W-1:0]   tcnt_q;
  logic [DATA_W-1:0] rdata_q;

  logic mem_phase;
  logic both_set;
  logic access;
  logic commit;

  assign mem_phase = phasecounter[PH_MEM];
  assign both_set  = in_MemRead & in_MemWrite;
  assign access    = in_MemRead ^ in_MemWrite;
  assign stall     = mem_phase & access & (state_q != ST_DONE);
  assign commit    = mem_phase & ~stall;
  assign dbg_state = state_q;

  // Memory handshake: mem_req rises with addr/we/wdata and stays high with
  // them stable until the first cycle mem_ack is seen (or the timeout fires);
  // mem_rdata is taken only in that cycle, and mem_ack outside REQ is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      rdata_q     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      led0        <= '0;
      led1        <= '0;
      wb_RegWrite <= 1'b0;
      wb_des      <= '0;
      wb_data     <= '0;
      mem_error   <= 1'b0;
    end else begin
      if (mem_phase && both_set) begin
        mem_error <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (mem_phase && access) begin
            state_q   <= ST_REQ;
            mem_req   <= 1'b1;
            mem_we    <= in_MemWrite;
            mem_addr  <= in_address;
            mem_wdata <= in_data;
            tcnt_q    <= '0;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q <= ST_DONE;
            mem_req <= 1'b0;
            rdata_q <= mem_rdata;
          end else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            // Abort: the load result reads as zero and the error sticks.
            state_q   <= ST_DONE;
            mem_req   <= 1'b0;
            rdata_q   <= '0;
            mem_error <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!mem_phase) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (commit) begin
        wb_RegWrite <= in_RegWrite;
        wb_des      <= in_des;
        wb_data     <= in_switchin ? switch_data :
                       in_MemtoReg ? rdata_q : in_address;
        if (in_ledout[LED0_BIT]) begin
          led0 <= in_data;
        end
        if (in_ledout[LED1_BIT]) begin
          led1 <= in_data;
        end
      end
    end
  end

endmodule
